// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: sweeps one of five fixed 3-input functions over minterms 0..7,
// captures its truth table and checks it against that function's expected minterm mask.
module truth_sweep_ctrl #(
  parameter int unsigned SETTLE = 1  // settle cycles per minterm, 0..15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] sel_i,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  output logic       r_dbg_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] table_o,
  output logic [7:0] mism_o,
  output logic       pass_o,
  output logic       err_o
);
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TBL_W  = 8;
  localparam int unsigned NUM_FN = 5;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  // Fixed function bank, evaluated at minterm m = {x,y,z}.
  function automatic logic fn_eval(input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] m);
    logic x, y, z, r;
    {x, y, z} = m;
    case (s)
      3'd0:    r = (x & y) | (~x & ~y & z);
      3'd1:    r = ~z & (x | y);
      3'd2:    r = y ^ z;
      3'd3:    r = (x & ~y) | (~x & (y ^ z));
      3'd4:    r = (x & y) | (~x & ~(y ^ z));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [TBL_W-1:0] fn_mask(input logic [IDX_W-1:0] s);
    logic [TBL_W-1:0] m;
    case (s)
      3'd0:    m = 8'hC2;
      3'd1:    m = 8'h54;
      3'd2:    m = 8'h66;
      3'd3:    m = 8'h36;
      3'd4:    m = 8'hC9;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [TBL_W-1:0] table_q, table_d;
  logic [TBL_W-1:0] mism_q, mism_d;
  logic             pass_q, pass_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             r_c;
  logic [TBL_W-1:0] mask_c;

  // Bank is driven by the latched select so mid-sweep sel changes are harmless.
  assign r_c    = fn_eval(sel_q, idx_q);
  assign mask_c = fn_mask(sel_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      table_q <= '0;
      mism_q  <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    table_d = table_q;
    mism_d  = mism_q;
    pass_d  = pass_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          table_d = '0;
          mism_d  = '0;
          pass_d  = 1'b0;
          if (sel_i < IDX_W'(NUM_FN)) begin
            state_d = SWEEP;
            sel_d   = sel_i;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      SWEEP: begin
        busy_d = 1'b1;
        if (cnt_q != CNT_W'(SETTLE)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          table_d[idx_q] = r_c;
          cnt_d          = '0;
          if (idx_q == IDX_W'(7)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            mism_d  = table_d ^ mask_c;
            pass_d  = (table_d == mask_c);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign {x_o, y_o, z_o} = idx_q;
  assign r_dbg_o = r_c;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign table_o = table_q;
  assign mism_o  = mism_q;
  assign pass_o  = pass_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Self-checking bench for truth_sweep_ctrl: three instances (SETTLE = 1, 0, 3) checked every
// cycle against a time-based behavioural model, plus directed literal expectations.
module tb_truth_sweep_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_r[3], start_r[3];
  logic [2:0] sel_r[3];
  logic       x_w[3], y_w[3], z_w[3], r_w[3], busy_w[3], done_w[3], pass_w[3], err_w[3];
  logic [7:0] tbl_w[3], mism_w[3];

  int n_chk = 0;
  int n_fail = 0;

  function automatic int settle_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    truth_sweep_ctrl #(.SETTLE(S)) u_dut (
      .clk_i(clk), .rst_i(rst_r[g]), .start_i(start_r[g]), .sel_i(sel_r[g]),
      .x_o(x_w[g]), .y_o(y_w[g]), .z_o(z_w[g]), .r_dbg_o(r_w[g]),
      .busy_o(busy_w[g]), .done_o(done_w[g]), .table_o(tbl_w[g]),
      .mism_o(mism_w[g]), .pass_o(pass_w[g]), .err_o(err_w[g])
    );
  end

  // Function equations and masks as stated for the bank; inj flips f2 at minterm 4.
  function automatic logic fbit(int s, int m, bit inj);
    logic x, y, z, r;
    x = 1'((m >> 2) & 1);
    y = 1'((m >> 1) & 1);
    z = 1'(m & 1);
    case (s)
      0:       r = (x & y) | (~x & ~y & z);
      1:       r = ~z & (x | y);
      2:       r = y ^ z;
      3:       r = (x & ~y) | (~x & (y ^ z));
      4:       r = (x & y) | (~x & ~(y ^ z));
      default: r = 1'b0;
    endcase
    if (inj && s == 1 && m == 4) r = ~r;
    return r;
  endfunction

  function automatic logic [7:0] mask_of(int s);
    case (s)
      0: return 8'hC2;
      1: return 8'h54;
      2: return 8'h66;
      3: return 8'h36;
      4: return 8'hC9;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(string name, int d, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 sweeping (k edges since accept), 2 done cycle.
  int         m_mode[3], m_k[3], m_sel[3];
  bit         m_valid[3];
  logic [2:0] m_xyz[3];
  logic [7:0] m_tbl[3], m_mism[3];
  logic       m_pass[3], m_err[3];
  bit         inj_on = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_r[d] === 1'b1) begin
        m_valid[d] = 1'b1;
        m_mode[d] = 0; m_k[d] = 0; m_sel[d] = 0; m_xyz[d] = 3'd0;
        m_tbl[d] = 8'h00; m_mism[d] = 8'h00; m_pass[d] = 1'b0; m_err[d] = 1'b0;
      end else if (m_valid[d]) begin
        case (m_mode[d])
          0: if (start_r[d]) begin
            m_tbl[d] = 8'h00; m_mism[d] = 8'h00; m_pass[d] = 1'b0;
            if (int'(sel_r[d]) < 5) begin
              m_mode[d] = 1; m_k[d] = 0; m_sel[d] = int'(sel_r[d]);
              m_err[d] = 1'b0; m_xyz[d] = 3'd0;
            end else begin
              m_mode[d] = 2; m_err[d] = 1'b1;
            end
          end
          1: begin
            int step, ncap;
            m_k[d]++;
            step = m_k[d] / (settle_of(d) + 1);
            m_xyz[d] = 3'((step > 7) ? 7 : step);
            ncap = (step > 8) ? 8 : step;
            m_tbl[d] = 8'h00;
            for (int i = 0; i < ncap; i++) m_tbl[d][i] = fbit(m_sel[d], i, inj_on && d == 0);
            if (m_k[d] == 8 * (settle_of(d) + 1)) begin
              m_mode[d] = 2;
              m_mism[d] = m_tbl[d] ^ mask_of(m_sel[d]);
              m_pass[d] = (m_tbl[d] == mask_of(m_sel[d]));
            end
          end
          default: m_mode[d] = 0;
        endcase
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (m_valid[d]) begin
        chk("busy", d, 8'(busy_w[d]), 8'(m_mode[d] == 1));
        chk("done", d, 8'(done_w[d]), 8'(m_mode[d] == 2));
        chk("err", d, 8'(err_w[d]), 8'(m_err[d]));
        chk("xyz", d, {5'd0, x_w[d], y_w[d], z_w[d]}, {5'd0, m_xyz[d]});
        chk("table", d, tbl_w[d], m_tbl[d]);
        if (m_mode[d] != 1) begin
          chk("pass", d, 8'(pass_w[d]), 8'(m_pass[d]));
          chk("mism", d, mism_w[d], m_mism[d]);
        end else if (!(d == 0 && inj_on)) begin
          chk("r_dbg", d, 8'(r_w[d]), 8'(fbit(m_sel[d], int'(m_xyz[d]), 1'b0)));
        end
      end
    end
  end

  task automatic wait_done(int d, int max, output int lat);
    lat = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_w[d]) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL done_timeout dut%0d: got no done within %0d cycles", d, max);
    lat = -1;
  endtask

  task automatic run_sweep(int d, int s, output int lat);
    @(negedge clk);
    start_r[d] = 1'b1;
    sel_r[d] = 3'(s);
    wait_done(d, 8 * (settle_of(d) + 1) + 5, lat);
    @(negedge clk);
    start_r[d] = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  forced, rel, got;
    for (int d = 0; d < 3; d++) begin
      rst_r[d] = 1'b1; start_r[d] = 1'b1; sel_r[d] = 3'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", d, 8'(busy_w[d]), 8'h00);
      chk("rst_table", d, tbl_w[d], 8'h00);
      chk("rst_xyz", d, {5'd0, x_w[d], y_w[d], z_w[d]}, 8'h00);
      rst_r[d] = 1'b0; start_r[d] = 1'b0;
    end

    // f1, SETTLE=1: done 16 edges after acceptance
    run_sweep(0, 0, lat);
    chk("f1_latency", 0, 8'(lat), 8'd17);
    chk("f1_table", 0, tbl_w[0], 8'hC2);
    chk("f1_mism", 0, mism_w[0], 8'h00);
    chk("f1_pass", 0, 8'(pass_w[0]), 8'h01);

    // Back-to-back f2..f5 with start held high and sel disturbed mid-sweep
    @(negedge clk);
    start_r[0] = 1'b1; sel_r[0] = 3'd1;
    wait_done(0, 40, lat);
    chk("b2b_first_lat", 0, 8'(lat), 8'd17);
    chk("b2b_f2_table", 0, tbl_w[0], 8'h54);
    chk("b2b_f2_pass", 0, 8'(pass_w[0]), 8'h01);
    for (int s = 2; s <= 4; s++) begin
      @(negedge clk);
      sel_r[0] = 3'(s);
      repeat (3) @(posedge clk);
      @(negedge clk);
      sel_r[0] = 3'($urandom_range(0, 7));
      wait_done(0, 40, lat);
      chk("b2b_gap", 0, 8'(lat + 3), 8'd18);
      chk("b2b_table", 0, tbl_w[0], (s == 2) ? 8'h66 : ((s == 3) ? 8'h36 : 8'hC9));
      chk("b2b_pass", 0, 8'(pass_w[0]), 8'h01);
    end
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (2) @(negedge clk);

    // Illegal select
    start_r[0] = 1'b1; sel_r[0] = 3'd6;
    @(posedge clk);
    #1;
    chk("ill_done", 0, 8'(done_w[0]), 8'h01);
    chk("ill_err", 0, 8'(err_w[0]), 8'h01);
    chk("ill_busy", 0, 8'(busy_w[0]), 8'h00);
    chk("ill_table", 0, tbl_w[0], 8'h00);
    chk("ill_pass", 0, 8'(pass_w[0]), 8'h00);
    @(negedge clk);
    start_r[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("ill_done_end", 0, 8'(done_w[0]), 8'h00);
    run_sweep(0, 2, lat);
    chk("after_ill_err", 0, 8'(err_w[0]), 8'h00);
    chk("after_ill_table", 0, tbl_w[0], 8'h66);
    chk("after_ill_pass", 0, 8'(pass_w[0]), 8'h01);

    // Reset sampled at T+7 of an f4 sweep
    @(negedge clk);
    start_r[0] = 1'b1; sel_r[0] = 3'd3;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_r[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 0, 8'(busy_w[0]), 8'h00);
    chk("midrst_done", 0, 8'(done_w[0]), 8'h00);
    chk("midrst_table", 0, tbl_w[0], 8'h00);
    chk("midrst_xyz", 0, {5'd0, x_w[0], y_w[0], z_w[0]}, 8'h00);
    @(negedge clk);
    rst_r[0] = 1'b0;
    repeat (20) @(negedge clk);
    run_sweep(0, 3, lat);
    chk("postrst_table", 0, tbl_w[0], 8'h36);

    // SETTLE=0 and SETTLE=3 instances on f5
    run_sweep(1, 4, lat);
    chk("s0_latency", 1, 8'(lat), 8'd9);
    chk("s0_table", 1, tbl_w[1], 8'hC9);
    run_sweep(2, 4, lat);
    chk("s3_latency", 2, 8'(lat), 8'd33);
    chk("s3_table", 2, tbl_w[2], 8'hC9);

    // f2 with its output inverted while minterm 4 is applied
    inj_on = 1'b1;
    forced = 1'b0; rel = 1'b0; got = 1'b0;
    @(negedge clk);
    start_r[0] = 1'b1; sel_r[0] = 3'd1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      start_r[0] = 1'b0;
      if (!forced && busy_w[0] && {x_w[0], y_w[0], z_w[0]} == 3'd4) begin
        force g_dut[0].u_dut.r_c = 1'b0;
        forced = 1'b1;
      end else if (forced && !rel && {x_w[0], y_w[0], z_w[0]} != 3'd4) begin
        release g_dut[0].u_dut.r_c;
        rel = 1'b1;
      end
      if (done_w[0]) got = 1'b1;
    end
    if (forced && !rel) release g_dut[0].u_dut.r_c;
    chk("inj_seen_done", 0, 8'(got), 8'h01);
    chk("inj_table", 0, tbl_w[0], 8'h44);
    chk("inj_mism", 0, mism_w[0], 8'h10);
    chk("inj_pass", 0, 8'(pass_w[0]), 8'h00);
    @(negedge clk);
    inj_on = 1'b0;

    // Random traffic on all instances, model-checked every cycle
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        rst_r[d]   = ($urandom_range(0, 199) == 0);
        start_r[d] = ($urandom_range(0, 3) != 0);
        sel_r[d]   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7))
                                                 : 3'($urandom_range(0, 4));
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rst_r[d] = 1'b0; start_r[d] = 1'b0;
    end
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_sweep_ctrl.md
# truth_sweep_ctrl

Sweep controller for the team's five 3-input boolean functions f1..f5. On a start request it selects one function, steps its inputs x,y,z through minterms 0..7 and captures the output into an 8-bit truth-table register. It then compares the result against that function's specified minterm mask and reports pass/fail and the mismatch pattern. It sits between a test/config host and the function bank, replacing hand-written stimulus sequences with a single self-checking hardware sweep.

## Interface
- SETTLE, default 1: settle cycles per minterm before capture; legal range 0..15.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- sel  in  3  function select: 0=f1, 1=f2, 2=f3, 3=f4, 4=f5; 5..7 illegal.
- x, y, z  out  1 each  stimulus currently applied to the selected function (x = MSB of minterm index).
- r_dbg  out  1  output of the selected function for the current x,y,z (combinational).
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at sweep end (also on an illegal-select reject).
- table  out  8  captured truth table; bit i = function output at minterm i.
- mism  out  8  table XOR expected mask.
- pass  out  1  table == expected mask, valid from done onward.
- err  out  1  last request had an illegal sel.

## Operation
- Internal function bank, all equations fixed:
  - f1 = (x&y)|(~x&~y&z), mask 0xC2, minterms 1,6,7.
  - f2 = ~z&(x|y), mask 0x54, minterms 2,4,6.
  - f3 = y^z, mask 0x66, minterms 1,2,5,6.
  - f4 = (x&~y)|(~x&(y^z)), mask 0x36, minterms 1,2,4,5.
  - f5 = (x&y)|(~x&~(y^z)), mask 0xC9, minterms 0,3,6,7.
- sel is latched at start acceptance. The r/mask mux uses the latched value, never live sel.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: start=1 with legal sel -> SWEEP. Clear idx, settle counter cnt and table. Clear err.
  - IDLE: start=1 with illegal sel -> DONE. Set err=1 and table=0; pass forced 0.
  - SWEEP: {x,y,z} = idx (3-bit register).
    - While cnt < SETTLE, increment cnt.
    - When cnt == SETTLE: table[idx] <= r, cnt <= 0.
    - If idx == 7, go to DONE; otherwise idx <= idx+1 (no wrap within a sweep).
  - DONE: done=1 for exactly one cycle, then IDLE.
- pass and mism are computed from the final table and the latched mask, registered on entry to DONE.
- table, mism, pass and err hold until the next accepted start or reset.
- start is ignored in SWEEP and DONE; no queuing.
- x,y,z hold the last applied value (7) after a sweep. After reset they are 0.

## Timing
- Reset (rst sampled high): state=IDLE, and all of the following are 0: idx, cnt, x, y, z, busy, done, table, mism, pass, err.
- Reset mid-sweep aborts the sweep with no done pulse. Reset wins over start on the same edge.
- Legal start sampled at edge T:
  - busy=1 from T.
  - Minterm i is captured at edge T+(i+1)·(SETTLE+1).
  - Edge T+8·(SETTLE+1) enters DONE: busy=0, done=1, pass/mism valid.
  - Edge T+8·(SETTLE+1)+1 returns to IDLE: done=0.
  - SETTLE=1 gives a 16-cycle sweep; SETTLE=0 gives 8 cycles (capture every edge).
- Illegal start at edge T: done=1 and err=1 from T for one cycle. busy stays 0.
- Start held high continuously: a new sweep is accepted on the first IDLE edge after DONE. Successive sweeps are therefore separated by exactly one DONE cycle.
- sel changes during SWEEP have no effect.

## Test plan
- Reset, then start with sel=0, SETTLE=1 -> busy for 16 cycles; done at T+16; table=0xC2, mism=0x00, pass=1.
- Back-to-back sweeps sel=1..4 with start held high -> tables 0x54, 0x66, 0x36, 0xC9, all pass=1. Exactly one done pulse per sweep, and each new sweep begins the edge after its done.
- sel=6 -> done and err high for one cycle at T; busy never high; table=0, pass=0. A following legal sweep with sel=2 clears err and passes.
- Assert rst at T+7 during a sel=3 sweep -> all outputs 0 on the next edge, no done pulse, FSM idle. A new start then completes normally with table=0x36.
- Rebuild with SETTLE=0 and sweep sel=4 -> done at T+8, table=0xC9. Rebuild with SETTLE=3 and sweep the same -> done at T+32. In both cases x,y,z step 0..7 and each value is held SETTLE+1 cycles.
- Force the internal f2 output to invert at minterm 4 -> table=0x44, mism=0x10, pass=0.
